// File: rtl/lfa_multiword_adder.sv
`timescale 1ns/1ps
// Wide sequential adder: drives one 16-bit Ladner-Fischer core a slice per cycle,
// least-significant slice first, with a registered carry linking the slices.
//   state | meaning
//   IDLE  | waiting for an operand pair, in_ready high
//   RUN   | one 16-bit slice passes through the core per cycle
//   DONE  | result held on out_sum until the consumer takes it

module lfa_multiword_adder #(
  parameter int WORDS = 4
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [16*WORDS-1:0]  in_a,
  input  logic [16*WORDS-1:0]  in_b,
  input  logic                 in_cin,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [16*WORDS:0]    out_sum,
  output logic                 busy
);

  localparam int W  = 16 * WORDS;
  localparam int IW = (WORDS > 1) ? $clog2(WORDS) : 1;
  localparam logic [IW-1:0] LAST = IW'(WORDS - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t        state, state_nxt;
  logic [1:0]    rst_sync;
  logic          rst_int_n;
  logic [W-1:0]  a_reg, b_reg, sum_reg, sum_nxt;
  logic          carry;
  logic [IW-1:0] idx;
  logic [15:0]   core_a, core_b, core_s;
  logic          core_cout;
  logic          accept, last_slice, handshake;

  // Reset asserts immediately; release is retimed through two flops on clk.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) rst_sync <= 2'b00;
    else        rst_sync <= {rst_sync[0], 1'b1};
  end

  assign rst_int_n = rst_sync[1];

  always_ff @(posedge clk or negedge rst_int_n) begin
    if (!rst_int_n) state <= IDLE;
    else            state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE:    if (in_valid)               state_nxt = RUN;
      RUN:     if (idx == LAST)            state_nxt = DONE;
      DONE:    if (out_valid && out_ready) state_nxt = IDLE;
      default:                             state_nxt = IDLE;
    endcase
  end

  // in_ready depends on state only, so out_ready never reaches it combinationally.
  always_comb begin
    in_ready   = 1'b0;
    busy       = 1'b0;
    accept     = 1'b0;
    last_slice = 1'b0;
    handshake  = 1'b0;
    unique case (state)
      IDLE: begin
        in_ready = 1'b1;
        accept   = in_valid;
      end
      RUN: begin
        busy       = 1'b1;
        last_slice = (idx == LAST);
      end
      DONE: begin
        busy      = 1'b1;
        handshake = out_valid & out_ready;
      end
      default: ;
    endcase
  end

  assign core_a = a_reg[{idx, 4'h0} +: 16];
  assign core_b = b_reg[{idx, 4'h0} +: 16];

  always_comb begin
    sum_nxt                     = sum_reg;
    sum_nxt[{idx, 4'h0} +: 16]  = core_s;
  end

  LadnerFischer16 u_core (
    .A    (core_a),
    .B    (core_b),
    .Cin  (carry),
    .S    (core_s),
    .Cout (core_cout)
  );

  always_ff @(posedge clk or negedge rst_int_n) begin
    if (!rst_int_n) begin
      a_reg     <= '0;
      b_reg     <= '0;
      sum_reg   <= '0;
      carry     <= 1'b0;
      idx       <= '0;
      out_sum   <= '0;
      out_valid <= 1'b0;
    end else begin
      if (accept) begin
        a_reg   <= in_a;
        b_reg   <= in_b;
        carry   <= in_cin;
        idx     <= '0;
        sum_reg <= '0;
      end
      if (state == RUN) begin
        sum_reg <= sum_nxt;
        carry   <= core_cout;
        if (last_slice) begin
          idx       <= '0;
          out_sum   <= {core_cout, sum_nxt};
          out_valid <= 1'b1;
        end else begin
          idx <= idx + 1'b1;
        end
      end
      if (handshake) out_valid <= 1'b0;
    end
  end

endmodule

// 16-bit Ladner-Fischer (minimum-depth) prefix adder; carry-in folded into bit 0 generate.
module LadnerFischer16 (
  input  logic [15:0] A,
  input  logic [15:0] B,
  input  logic        Cin,
  output logic [15:0] S,
  output logic        Cout
);

  logic [15:0] g [0:4];
  logic [15:0] p [0:3];

  assign p[0] = A ^ B;
  assign g[0] = {A[15:1] & B[15:1], (A[0] & B[0]) | ((A[0] ^ B[0]) & Cin)};

  for (genvar l = 0; l < 4; l++) begin : g_lvl
    for (genvar i = 0; i < 16; i++) begin : g_bit
      if (((i >> l) & 1) == 1) begin : g_op
        localparam int J = ((i >> l) << l) - 1;
        assign g[l+1][i] = g[l][i] | (p[l][i] & g[l][J]);
        if (l < 3) begin : g_p
          assign p[l+1][i] = p[l][i] & p[l][J];
        end
      end else begin : g_pass
        assign g[l+1][i] = g[l][i];
        if (l < 3) begin : g_p
          assign p[l+1][i] = p[l][i];
        end
      end
    end
  end

  assign S    = p[0] ^ {g[4][14:0], Cin};
  assign Cout = g[4][15];

endmodule

// File: tb/tb_lfa_multiword_adder.sv
`timescale 1ns/1ps
// Scoreboard bench for lfa_multiword_adder: a WORDS=4 instance and a WORDS=1 instance.
module tb_lfa_multiword_adder;

  localparam time HALF = 5;
  localparam time PER  = 10;

  typedef struct {
    logic [64:0] sum;
    time         t;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        iv4, ir4, cin4, ov4, or4, busy4;
  logic [63:0] a4, b4;
  logic [64:0] s4;
  logic        iv1, ir1, cin1, ov1, or1, busy1;
  logic [15:0] a1, b1;
  logic [16:0] s1;

  exp_t        q4[$];
  exp_t        q1[$];
  exp_t        e4, e1;
  time         rise4[$];
  int          tests = 0;
  int          fails = 0;
  logic        pv4 = 1'b0;
  logic        pv1 = 1'b0;
  logic        d4, d1, seen;
  logic [64:0] held;
  int          n;

  always #HALF clk = ~clk;

  lfa_multiword_adder #(.WORDS(4)) u4 (
    .clk(clk), .rst_n(rst_n), .in_valid(iv4), .in_ready(ir4), .in_a(a4), .in_b(b4),
    .in_cin(cin4), .out_valid(ov4), .out_ready(or4), .out_sum(s4), .busy(busy4)
  );

  lfa_multiword_adder #(.WORDS(1)) u1 (
    .clk(clk), .rst_n(rst_n), .in_valid(iv1), .in_ready(ir1), .in_a(a1), .in_b(b1),
    .in_cin(cin1), .out_valid(ov1), .out_ready(or1), .out_sum(s1), .busy(busy1)
  );

  task automatic chk(input string nm, input logic [64:0] act, input logic [64:0] req);
    tests++;
    if (act !== req) begin
      fails++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, req);
    end
  endtask

  // Monitors: pop and compare on every handshake, check latency on each out_valid rise.
  always @(negedge clk) begin
    if (rst_n) begin
      if (ov4 && !pv4) begin
        rise4.push_back($time);
        if (q4.size() > 0) chk("u4 latency", 65'((($time - HALF) - q4[0].t) / PER), 65'd4);
      end
      if (ov4 && or4) begin
        if (q4.size() == 0) begin
          tests++; fails++;
          $display("FAIL u4 spurious result: got 0x%0h expected none", s4);
        end else begin
          e4 = q4.pop_front();
          chk("u4 sum", s4, e4.sum);
        end
      end
    end
    pv4 = ov4;
  end

  always @(negedge clk) begin
    if (rst_n) begin
      if (ov1 && !pv1 && q1.size() > 0)
        chk("u1 latency", 65'((($time - HALF) - q1[0].t) / PER), 65'd1);
      if (ov1 && or1) begin
        if (q1.size() == 0) begin
          tests++; fails++;
          $display("FAIL u1 spurious result: got 0x%0h expected none", s1);
        end else begin
          e1 = q1.pop_front();
          chk("u1 sum", {48'd0, s1}, e1.sum);
        end
      end
    end
    pv1 = ov1;
  end

  task automatic send4(input logic [63:0] a, input logic [63:0] b, input logic c,
                       input logic [64:0] e);
    int k = 0;
    @(negedge clk);
    while (!ir4 && k < 200) begin @(negedge clk); k++; end
    if (!ir4) begin
      tests++; fails++;
      $display("FAIL u4 accept timeout: in_ready 0 expected 1");
      return;
    end
    a4 = a; b4 = b; cin4 = c; iv4 = 1'b1;
    @(posedge clk);
    q4.push_back('{sum: e, t: $time});
    #1;
    iv4 = 1'b0; a4 = ~a; b4 = ~b; cin4 = ~c;
  endtask

  task automatic send1(input logic [15:0] a, input logic [15:0] b, input logic c,
                       input logic [64:0] e);
    int k = 0;
    @(negedge clk);
    while (!ir1 && k < 200) begin @(negedge clk); k++; end
    if (!ir1) begin
      tests++; fails++;
      $display("FAIL u1 accept timeout: in_ready 0 expected 1");
      return;
    end
    a1 = a; b1 = b; cin1 = c; iv1 = 1'b1;
    @(posedge clk);
    q1.push_back('{sum: e, t: $time});
    #1;
    iv1 = 1'b0; a1 = ~a; b1 = ~b; cin1 = ~c;
  endtask

  task automatic drain4();
    int k = 0;
    while (q4.size() != 0 && k < 2000) begin @(negedge clk); k++; end
    if (q4.size() != 0) begin
      tests++; fails++;
      $display("FAIL u4 drain timeout: %0d results outstanding, expected 0", q4.size());
      q4.delete();
    end
  endtask

  task automatic drain1();
    int k = 0;
    while (q1.size() != 0 && k < 2000) begin @(negedge clk); k++; end
    if (q1.size() != 0) begin
      tests++; fails++;
      $display("FAIL u1 drain timeout: %0d results outstanding, expected 0", q1.size());
      q1.delete();
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b1;
    iv4 = 1'b0; a4 = '0; b4 = '0; cin4 = 1'b0; or4 = 1'b1;
    iv1 = 1'b0; a1 = '0; b1 = '0; cin1 = 1'b0; or1 = 1'b1;
    #1 rst_n = 1'b0;
    #2;
    chk("rst out_valid", ov4, 0);
    chk("rst out_sum", s4, 0);
    chk("rst busy", busy4, 0);
    chk("rst in_ready", ir4, 1);
    chk("rst u1 in_ready", ir1, 1);
    repeat (3) @(posedge clk);
    @(negedge clk) rst_n = 1'b1;
    repeat (3) @(negedge clk);

    // Reset asserted without a clock edge during the second RUN cycle.
    send4(64'h3, 64'h4, 1'b0, 65'h7);
    @(posedge clk);
    #2 rst_n = 1'b0;
    q4.delete();
    #1;
    chk("abort out_valid", ov4, 0);
    chk("abort busy", busy4, 0);
    chk("abort in_ready", ir4, 1);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    seen = 1'b0;
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      if (ov4) seen = 1'b1;
    end
    chk("abort no result", seen, 0);
    send4(64'h3, 64'h4, 1'b0, 65'h0_0000_0000_0000_0007);
    drain4();

    // Full carry ripple across all slices.
    send4(64'hFFFF_FFFF_FFFF_FFFF, 64'h0, 1'b1, 65'h1_0000_0000_0000_0000);
    send4(64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF, 1'b1, 65'h1_FFFF_FFFF_FFFF_FFFF);
    send4(64'h0000_FFFF_0000_FFFF, 64'h0000_0001_0000_0001, 1'b0, 65'h0_0001_0000_0001_0000);
    drain4();

    // Back-to-back with out_ready high.
    rise4.delete();
    send4(64'h1234_5678_9ABC_DEF0, 64'h1111_1111_1111_1111, 1'b0, 65'h0_2345_6789_ABCD_F001);
    send4(64'h8000_0000_0000_0000, 64'h8000_0000_0000_0000, 1'b0, 65'h1_0000_0000_0000_0000);
    send4(64'h0, 64'h0, 1'b0, 65'h0);
    drain4();
    repeat (2) @(negedge clk);
    chk("b2b result count", 65'(rise4.size()), 65'd3);
    if (rise4.size() == 3) begin
      chk("b2b spacing 1", 65'((rise4[1] - rise4[0]) / PER), 65'd6);
      chk("b2b spacing 2", 65'((rise4[2] - rise4[1]) / PER), 65'd6);
    end

    // Backpressure: result held, new operands ignored, single handshake.
    @(posedge clk);
    #1 or4 = 1'b0;
    send4(64'h0123_4567_89AB_CDEF, 64'h1111_1111_1111_1111, 1'b0, 65'h0_1234_5678_9ABC_DF00);
    n = 0;
    while (!ov4 && n < 50) begin @(negedge clk); n++; end
    chk("bp out_valid", ov4, 1);
    held = s4;
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      if (k >= 2 && k < 6) begin
        iv4 = 1'b1; a4 = 64'hDEAD_BEEF; b4 = 64'h1; cin4 = 1'b0;
      end else begin
        iv4 = 1'b0;
      end
      chk("bp sum held", s4, held);
      chk("bp in_ready", ir4, 0);
      chk("bp busy", busy4, 1);
    end
    @(posedge clk);
    #1 or4 = 1'b1;
    @(negedge clk);
    chk("bp in_ready at handshake", ir4, 0);
    @(negedge clk);
    chk("bp in_ready after", ir4, 1);
    chk("bp out_valid after", ov4, 0);
    drain4();
    repeat (12) @(negedge clk);

    // Single-slice instance.
    send1(16'hFFFF, 16'h0001, 1'b0, 65'h1_0000);
    send1(16'h8000, 16'h7FFF, 1'b1, 65'h1_0000);
    send1(16'h1234, 16'h4321, 1'b0, 65'h0_5555);
    send1(16'h0000, 16'h0000, 1'b1, 65'h0_0001);
    drain1();

    // Random operands with random consumer stalls on both instances.
    d4 = 1'b0;
    d1 = 1'b0;
    fork
      begin
        for (int k = 0; k < 150; k++) begin
          logic [63:0] ra, rb;
          logic        rc;
          ra = {$urandom, $urandom};
          rb = {$urandom, $urandom};
          rc = 1'($urandom_range(0, 1));
          send4(ra, rb, rc, {1'b0, ra} + {1'b0, rb} + {64'd0, rc});
        end
        d4 = 1'b1;
      end
      begin
        while (!d4) begin
          @(posedge clk);
          #1 or4 = ($urandom_range(0, 3) != 0);
        end
        or4 = 1'b1;
      end
      begin
        for (int k = 0; k < 150; k++) begin
          logic [15:0] ra, rb;
          logic        rc;
          ra = 16'($urandom);
          rb = 16'($urandom);
          rc = 1'($urandom_range(0, 1));
          send1(ra, rb, rc, {48'd0, {1'b0, ra} + {1'b0, rb} + {16'd0, rc}});
        end
        d1 = 1'b1;
      end
      begin
        while (!d1) begin
          @(posedge clk);
          #1 or1 = ($urandom_range(0, 2) != 0);
        end
        or1 = 1'b1;
      end
    join
    drain4();
    drain1();
    repeat (10) @(negedge clk);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
